// File: rtl/rtlola_verdict_collector.sv
// Collects active monitor output cycles into a record FIFO and streams each record as header + value words.
// Optional macro VERDICT_TIMESTAMP_EN: header carries the cycle timestamp instead of the record sequence number.
module rtlola_verdict_collector #(
    parameter int N_OUT  = 3,
    parameter int DATA_W = 64,
    parameter int TS_W   = 32,
    parameter int DEPTH  = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    en_i,
    input  logic [N_OUT*DATA_W-1:0] out_data_i,
    input  logic [N_OUT-1:0]        out_aktv_i,
    output logic                    m_valid_o,
    input  logic                    m_ready_i,
    output logic [DATA_W-1:0]       m_data_o,
    output logic [7:0]              m_tag_o,
    output logic                    m_last_o,
    output logic                    overflow_o,
    output logic [15:0]             drop_count_o
);

    localparam int AW    = $clog2(DEPTH);
    localparam int IDX_W = (N_OUT > 1) ? $clog2(N_OUT) : 1;
    localparam logic [AW:0] CNT_ONE   = {{AW{1'b0}}, 1'b1};
    localparam logic [AW:0] CNT_DEPTH = DEPTH[AW:0];

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        VAL  = 2'd2
    } state_e;

    function automatic logic [IDX_W-1:0] first_set(input logic [N_OUT-1:0] mask, input int start);
        logic             found;
        logic [IDX_W-1:0] res;
        found = 1'b0;
        res   = '0;
        for (int i = 0; i < N_OUT; i++) begin
            if (!found && mask[i] && (i >= start)) begin
                res   = IDX_W'(i);
                found = 1'b1;
            end
        end
        return res;
    endfunction

    function automatic logic [IDX_W-1:0] last_set(input logic [N_OUT-1:0] mask);
        logic [IDX_W-1:0] res;
        res = '0;
        for (int i = 0; i < N_OUT; i++) begin
            if (mask[i]) begin
                res = IDX_W'(i);
            end
        end
        return res;
    endfunction

    function automatic logic [DATA_W-1:0] value_of(input logic [N_OUT*DATA_W-1:0] data,
                                                   input logic [IDX_W-1:0] idx);
        logic [DATA_W-1:0] v;
        v = '0;
        for (int i = 0; i < N_OUT; i++) begin
            if (IDX_W'(i) == idx) begin
                v = data[i*DATA_W +: DATA_W];
            end
        end
        return v;
    endfunction

    function automatic logic [DATA_W-1:0] hdr_word(input logic [N_OUT-1:0] mask, input logic [TS_W-1:0] ts);
        logic [DATA_W-1:0] w;
        w = '0;
        w[TS_W-1:0]      = ts;
        w[TS_W +: N_OUT] = mask;
        return w;
    endfunction

    logic [AW:0]             wr_ptr_q, rd_ptr_q;
    logic [TS_W-1:0]         mem_ts_q   [DEPTH];
    logic [N_OUT-1:0]        mem_mask_q [DEPTH];
    logic [N_OUT*DATA_W-1:0] mem_data_q [DEPTH];

    state_e            state_q;
    logic [IDX_W-1:0]  idx_q;
    logic              m_valid_q, m_last_q, overflow_q;
    logic [DATA_W-1:0] m_data_q;
    logic [7:0]        m_tag_q;
    logic [15:0]       drop_count_q;

    logic [AW:0]             count_s;
    logic                    empty_s, full_s, cap_s, pop_s, push_s, drop_s;
    logic [AW-1:0]           rd_idx_s, nxt_rd_idx_s;
    logic [N_OUT-1:0]        head_mask_s, nhead_mask_s;
    logic [TS_W-1:0]         head_ts_s, nhead_ts_s, field_s;
    logic [N_OUT*DATA_W-1:0] head_data_s;
    logic [IDX_W-1:0]        first_idx_s, next_idx_s, last_idx_s;

    assign count_s      = wr_ptr_q - rd_ptr_q;
    assign empty_s      = (count_s == '0);
    assign full_s       = (count_s == CNT_DEPTH);
    assign cap_s        = en_i & (|out_aktv_i);
    assign pop_s        = (state_q == VAL) & m_valid_q & m_ready_i & m_last_q;
    // The head slot frees up on the same edge when its last word leaves, so a full FIFO can still accept.
    assign push_s       = cap_s & (~full_s | pop_s);
    assign drop_s       = cap_s & full_s & ~pop_s;

    assign rd_idx_s     = rd_ptr_q[AW-1:0];
    assign nxt_rd_idx_s = rd_idx_s + AW'(1);
    assign head_mask_s  = mem_mask_q[rd_idx_s];
    assign head_ts_s    = mem_ts_q[rd_idx_s];
    assign head_data_s  = mem_data_q[rd_idx_s];
    assign nhead_mask_s = mem_mask_q[nxt_rd_idx_s];
    assign nhead_ts_s   = mem_ts_q[nxt_rd_idx_s];

    assign first_idx_s  = first_set(head_mask_s, 0);
    assign next_idx_s   = first_set(head_mask_s, int'(idx_q) + 1);
    assign last_idx_s   = last_set(head_mask_s);

`ifdef VERDICT_TIMESTAMP_EN
    logic [TS_W-1:0] ts_q;

    // Free-running cycle timestamp, frozen while capture is disabled.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ts_q <= '0;
        end else if (en_i) begin
            ts_q <= ts_q + TS_W'(1);
        end
    end

    assign field_s = ts_q;
`else
    logic [TS_W-1:0] seq_q;

    // Sequence number of accepted records; dropped records leave it untouched.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            seq_q <= '0;
        end else if (push_s) begin
            seq_q <= seq_q + TS_W'(1);
        end
    end

    assign field_s = seq_q;
`endif

    // Record storage; only the pointers carry reset state.
    always_ff @(posedge clk_i) begin
        if (push_s) begin
            mem_ts_q[wr_ptr_q[AW-1:0]]   <= field_s;
            mem_mask_q[wr_ptr_q[AW-1:0]] <= out_aktv_i;
            mem_data_q[wr_ptr_q[AW-1:0]] <= out_data_i;
        end
    end

    // FIFO pointers and drop accounting.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            overflow_q   <= 1'b0;
            drop_count_q <= 16'd0;
        end else begin
            if (push_s) begin
                wr_ptr_q <= wr_ptr_q + CNT_ONE;
            end
            if (pop_s) begin
                rd_ptr_q <= rd_ptr_q + CNT_ONE;
            end
            if (drop_s) begin
                overflow_q <= 1'b1;
                if (drop_count_q != 16'hFFFF) begin
                    drop_count_q <= drop_count_q + 16'd1;
                end
            end
        end
    end

    // Output FSM: every output register is loaded on the transition that presents the word.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_tag_q   <= 8'd0;
            m_last_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!empty_s) begin
                        state_q   <= HDR;
                        m_valid_q <= 1'b1;
                        m_data_q  <= hdr_word(head_mask_s, head_ts_s);
                        m_tag_q   <= 8'd0;
                        m_last_q  <= 1'b0;
                    end
                end
                HDR: begin
                    if (m_ready_i) begin
                        state_q  <= VAL;
                        idx_q    <= first_idx_s;
                        m_data_q <= value_of(head_data_s, first_idx_s);
                        m_tag_q  <= 8'(first_idx_s) + 8'd1;
                        m_last_q <= (first_idx_s == last_idx_s);
                    end
                end
                VAL: begin
                    if (m_ready_i) begin
                        if (m_last_q) begin
                            // Remaining records follow immediately with no idle gap.
                            if (count_s > CNT_ONE) begin
                                state_q  <= HDR;
                                m_data_q <= hdr_word(nhead_mask_s, nhead_ts_s);
                            end else begin
                                state_q   <= IDLE;
                                m_valid_q <= 1'b0;
                                m_data_q  <= '0;
                            end
                            idx_q    <= '0;
                            m_tag_q  <= 8'd0;
                            m_last_q <= 1'b0;
                        end else begin
                            idx_q    <= next_idx_s;
                            m_data_q <= value_of(head_data_s, next_idx_s);
                            m_tag_q  <= 8'(next_idx_s) + 8'd1;
                            m_last_q <= (next_idx_s == last_idx_s);
                        end
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    idx_q     <= '0;
                    m_valid_q <= 1'b0;
                    m_data_q  <= '0;
                    m_tag_q   <= 8'd0;
                    m_last_q  <= 1'b0;
                end
            endcase
        end
    end

    assign m_valid_o    = m_valid_q;
    assign m_data_o     = m_data_q;
    assign m_tag_o      = m_tag_q;
    assign m_last_o     = m_last_q;
    assign overflow_o   = overflow_q;
    assign drop_count_o = drop_count_q;

endmodule

// File: tb/tb_rtlola_verdict_collector.sv
// Directed bench for rtlola_verdict_collector; header field expectations follow VERDICT_TIMESTAMP_EN.
module tb_rtlola_verdict_collector;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         en;
    logic [191:0] out_data;
    logic [2:0]   out_aktv;
    logic         m_valid;
    logic         m_ready;
    logic [63:0]  m_data;
    logic [7:0]   m_tag;
    logic         m_last;
    logic         overflow;
    logic [15:0]  drop_count;

    rtlola_verdict_collector dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .en_i         (en),
        .out_data_i   (out_data),
        .out_aktv_i   (out_aktv),
        .m_valid_o    (m_valid),
        .m_ready_i    (m_ready),
        .m_data_o     (m_data),
        .m_tag_o      (m_tag),
        .m_last_o     (m_last),
        .overflow_o   (overflow),
        .drop_count_o (drop_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]       mask;
        logic [31:0]      ts;
        logic [31:0]      seq;
        logic [2:0][63:0] v;
    } rec_t;

    rec_t        exp_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] mdl_ts   = 32'd0;
    logic [31:0] mdl_seq  = 32'd0;
    logic [63:0] hdr0;
    rec_t        r0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (en && rst_n) mdl_ts = mdl_ts + 32'd1;
        #1;
    endtask

    function automatic logic [63:0] make_hdr(input logic [2:0] mask, input logic [31:0] ts, input logic [31:0] seq);
        logic [63:0] h;
        h = 64'd0;
`ifdef VERDICT_TIMESTAMP_EN
        h[31:0] = ts;
`else
        h[31:0] = seq;
`endif
        h[34:32] = mask;
        return h;
    endfunction

    task automatic push_rec(input logic [2:0] mask, input logic [63:0] v0, input logic [63:0] v1,
                            input logic [63:0] v2, input bit accepted);
        rec_t r;
        r.mask = mask;
        r.ts   = mdl_ts;
        r.seq  = mdl_seq;
        r.v[0] = v0;
        r.v[1] = v1;
        r.v[2] = v2;
        out_aktv = mask;
        out_data = {v2, v1, v0};
        tick();
        out_aktv = 3'b000;
        if (accepted) begin
            exp_q.push_back(r);
            mdl_seq = mdl_seq + 32'd1;
        end
    endtask

    task automatic expect_word(input string tag, input logic [63:0] d, input logic [7:0] t, input logic l);
        int n;
        n = 0;
        while (!m_valid && n < 20) begin
            tick();
            n++;
        end
        if (!m_valid) begin
            check_eq({tag, "_valid"}, 64'(m_valid), 64'd1);
        end else begin
            check_eq({tag, "_data"}, m_data, d);
            check_eq({tag, "_tag"}, 64'(m_tag), 64'(t));
            check_eq({tag, "_last"}, 64'(m_last), 64'(l));
            tick();
        end
    endtask

    task automatic drain(input string tag);
        rec_t r;
        int   hi;
        m_ready = 1'b1;
        while (exp_q.size() > 0) begin
            r  = exp_q.pop_front();
            hi = 0;
            for (int i = 0; i < 3; i++) if (r.mask[i]) hi = i;
            expect_word({tag, "_hdr"}, make_hdr(r.mask, r.ts, r.seq), 8'd0, 1'b0);
            for (int i = 0; i < 3; i++) begin
                if (r.mask[i]) expect_word({tag, "_val"}, r.v[i], 8'(i + 1), (i == hi));
            end
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        en       = 1'b0;
        out_aktv = 3'b000;
        out_data = 192'd0;
        m_ready  = 1'b1;
        #12;
        check_eq("rst_valid", 64'(m_valid), 64'd0);
        check_eq("rst_data", m_data, 64'd0);
        check_eq("rst_tag", 64'(m_tag), 64'd0);
        check_eq("rst_last", 64'(m_last), 64'd0);
        check_eq("rst_ovf", 64'(overflow), 64'd0);
        check_eq("rst_drop", 64'(drop_count), 64'd0);
        rst_n = 1'b1;
        en    = 1'b1;

        // Case 1: all three active at ts=5, check first-header latency.
        for (int i = 0; i < 5; i++) tick();
        push_rec(3'b111, 64'd1, 64'd2, 64'd3, 1'b1);
        check_eq("t1_lat0", 64'(m_valid), 64'd0);
        tick();
        check_eq("t1_lat1", 64'(m_valid), 64'd1);
`ifdef VERDICT_TIMESTAMP_EN
        check_eq("t1_hdr_const", m_data, 64'h7_0000_0005);
`else
        check_eq("t1_hdr_const", m_data, 64'h7_0000_0000);
`endif
        drain("t1");

        // Case 2: single active output with a negative value.
        push_rec(3'b010, 64'd0, 64'hFFFF_FFFF_FFFF_FFFC, 64'd0, 1'b1);
        drain("t2");

        // Case 3: sink stalled, 17 pushes into a 16-deep FIFO.
        m_ready = 1'b0;
        hdr0 = make_hdr(3'b001, mdl_ts, mdl_seq);
        for (int k = 0; k < 17; k++) begin
            push_rec(3'b001, 64'd100 + 64'(k), 64'd0, 64'd0, (k < 16));
            if (k >= 1) check_eq("t3_stable", m_data, hdr0);
            if (k == 15) check_eq("t3_ovf_pre", 64'(overflow), 64'd0);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("t3_hold", m_data, hdr0);
            check_eq("t3_hold_valid", 64'(m_valid), 64'd1);
        end
        check_eq("t3_ovf", 64'(overflow), 64'd1);
        check_eq("t3_drop", 64'(drop_count), 64'd1);

        // Case 4: full FIFO, push on the same edge the head's last word leaves.
        r0 = exp_q.pop_front();
        m_ready = 1'b1;
        expect_word("t4_hdr", make_hdr(r0.mask, r0.ts, r0.seq), 8'd0, 1'b0);
        check_eq("t4_val_data", m_data, 64'd100);
        check_eq("t4_val_tag", 64'(m_tag), 64'd1);
        check_eq("t4_val_last", 64'(m_last), 64'd1);
        push_rec(3'b001, 64'd200, 64'd0, 64'd0, 1'b1);
        check_eq("t4_drop", 64'(drop_count), 64'd1);
        check_eq("t4_ovf", 64'(overflow), 64'd1);
        drain("t4");

        // Case 5: capture disabled while queued records drain.
        m_ready = 1'b0;
        push_rec(3'b101, 64'd11, 64'd0, 64'd13, 1'b1);
        push_rec(3'b100, 64'd0, 64'd0, 64'h8000_0000_0000_0000, 1'b1);
        en       = 1'b0;
        out_aktv = 3'b001;
        out_data = {64'd0, 64'd0, 64'd55};
        drain("t5");
        for (int i = 0; i < 10; i++) tick();
        check_eq("t5_no_rec", 64'(m_valid), 64'd0);
        out_aktv = 3'b000;
        en       = 1'b1;
        push_rec(3'b001, 64'd77, 64'd0, 64'd0, 1'b1);
        drain("t5_after");

        // Case 6: reset in the middle of a record while ready toggles.
        m_ready = 1'b0;
        push_rec(3'b111, 64'd7, 64'd8, 64'd9, 1'b1);
        push_rec(3'b001, 64'd10, 64'd0, 64'd0, 1'b1);
        tick();
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        tick();
        m_ready = 1'b1;
        tick();
        check_eq("t6_pre_tag", 64'(m_tag), 64'd2);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("t6_valid", 64'(m_valid), 64'd0);
        check_eq("t6_data", m_data, 64'd0);
        check_eq("t6_tag", 64'(m_tag), 64'd0);
        check_eq("t6_last", 64'(m_last), 64'd0);
        check_eq("t6_ovf", 64'(overflow), 64'd0);
        check_eq("t6_drop", 64'(drop_count), 64'd0);
        en = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        mdl_ts  = 32'd0;
        mdl_seq = 32'd0;
        exp_q.delete();
        for (int i = 0; i < 3; i++) tick();
        check_eq("t6_empty", 64'(m_valid), 64'd0);
        en = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        push_rec(3'b111, 64'd1, 64'd2, 64'd3, 1'b1);
        push_rec(3'b111, 64'd4, 64'd5, 64'd6, 1'b1);
        drain("t6_rerun");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
